// File: rtl/conv_out_requant_if.sv
// Stream and configuration bundle for conv_out_requant: config handshake,
// wide accumulator input stream and narrow tagged output stream.
interface conv_out_requant_if #(
  parameter int ACCW = 40,
  parameter int OW   = 16,
  parameter int MAXK = 5
);
  localparam int SHW = $clog2(ACCW);
  localparam int KW  = $clog2(MAXK + 1);

  logic [KW-1:0]   CFG_K;
  logic [SHW-1:0]  CFG_SHIFT;
  logic            CFG_VALID;
  logic            CFG_READY;
  logic            CFG_ERR;
  logic [ACCW-1:0] IN_TDATA;
  logic            IN_TVALID;
  logic            IN_TREADY;
  logic [OW-1:0]   OUT_TDATA;
  logic            OUT_TVALID;
  logic            OUT_TREADY;
  logic            OUT_TLAST;
  logic            OUT_TUSER;

  modport master (
    output CFG_K, CFG_SHIFT, CFG_VALID, IN_TDATA, IN_TVALID, OUT_TREADY,
    input  CFG_READY, CFG_ERR, IN_TREADY, OUT_TDATA, OUT_TVALID, OUT_TLAST, OUT_TUSER
  );

  modport slave (
    input  CFG_K, CFG_SHIFT, CFG_VALID, IN_TDATA, IN_TVALID, OUT_TREADY,
    output CFG_READY, CFG_ERR, IN_TREADY, OUT_TDATA, OUT_TVALID, OUT_TLAST, OUT_TUSER
  );
endinterface

// File: rtl/conv_out_requant.sv
// Requantiser behind the conv core: rounding shift, saturation, row/frame tagging.
// Optional macro CONV_OUT_RELU_EN clamps negative results to zero before saturation.
module conv_out_requant #(
  parameter int R    = 8,
  parameter int C    = 8,
  parameter int MAXK = 5,
  parameter int ACCW = 40,
  parameter int OW   = 16
) (
  input logic clk,
  input logic reset,
  conv_out_requant_if.slave bus
);
  localparam int SHW   = $clog2(ACCW);
  localparam int KW    = $clog2(MAXK + 1);
  localparam int TW    = ACCW + 1;
  localparam int RW    = $clog2(R + 1);
  localparam int CW    = $clog2(C + 1);
  localparam int MINRC = (R < C) ? R : C;
  localparam logic signed [TW-1:0] SAT_MAX = {{(TW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [TW-1:0] SAT_MIN = {{(TW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state_reg;
  logic [KW-1:0]        k_reg;
  logic [SHW-1:0]       shift_reg;
  logic [RW-1:0]        row_reg;
  logic [CW-1:0]        col_reg;
  logic                 cfg_err_reg;
  logic                 s1_valid_reg, s1_last_reg, s1_user_reg;
  logic signed [TW-1:0] s1_t_reg;
  logic                 s2_valid_reg, s2_last_reg, s2_user_reg;
  logic [OW-1:0]        s2_data_reg;

  logic                 s2_adv, s1_adv, in_fire, out_fire, k_legal;
  logic                 at_col_last, at_row_last;
  logic [CW-1:0]        col_last;
  logic [RW-1:0]        row_last;
  logic signed [TW-1:0] in_ext, half, rounded;
  logic [OW-1:0]        sat;

  assign s2_adv   = !s2_valid_reg || bus.OUT_TREADY;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign in_fire  = bus.IN_TREADY && bus.IN_TVALID;
  assign out_fire = s2_valid_reg && bus.OUT_TREADY;
  assign k_legal  = (bus.CFG_K != '0) && (int'(bus.CFG_K) <= MAXK) && (int'(bus.CFG_K) <= MINRC);

  // Last column/row indices of the (R-K+1) x (C-K+1) output frame.
  assign col_last    = CW'(C) - CW'(k_reg);
  assign row_last    = RW'(R) - RW'(k_reg);
  assign at_col_last = (col_reg == col_last);
  assign at_row_last = (row_reg == row_last);

  // One extra bit of headroom so adding the rounding half never wraps.
  assign in_ext  = {bus.IN_TDATA[ACCW-1], bus.IN_TDATA};
  assign half    = (shift_reg == '0) ? '0 : (TW'(1) << (shift_reg - SHW'(1)));
  assign rounded = (in_ext + half) >>> shift_reg;

  always_comb begin
    sat = s1_t_reg[OW-1:0];
`ifdef CONV_OUT_RELU_EN
    if (s1_t_reg[TW-1])
      sat = '0;
    else if (s1_t_reg > SAT_MAX)
      sat = SAT_MAX[OW-1:0];
`else
    if (s1_t_reg > SAT_MAX)
      sat = SAT_MAX[OW-1:0];
    else if (s1_t_reg < SAT_MIN)
      sat = SAT_MIN[OW-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      k_reg        <= '0;
      shift_reg    <= '0;
      row_reg      <= '0;
      col_reg      <= '0;
      cfg_err_reg  <= 1'b0;
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_user_reg  <= 1'b0;
      s1_t_reg     <= '0;
      s2_valid_reg <= 1'b0;
      s2_last_reg  <= 1'b0;
      s2_user_reg  <= 1'b0;
      s2_data_reg  <= '0;
    end else begin
      cfg_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.CFG_VALID) begin
            k_reg     <= bus.CFG_K;
            shift_reg <= bus.CFG_SHIFT;
            row_reg   <= '0;
            col_reg   <= '0;
            if (k_legal)
              state_reg <= RUN;
            else
              cfg_err_reg <= 1'b1;
          end
        end
        RUN: begin
          if (in_fire) begin
            if (at_col_last) begin
              col_reg <= '0;
              row_reg <= row_reg + RW'(1);
              if (at_row_last)
                state_reg <= DRAIN;
            end else begin
              col_reg <= col_reg + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (out_fire && s2_user_reg)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      if (s1_adv) begin
        s1_valid_reg <= in_fire;
        if (in_fire) begin
          s1_t_reg    <= rounded;
          s1_last_reg <= at_col_last;
          s1_user_reg <= at_col_last && at_row_last;
        end
      end

      if (s2_adv) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_data_reg <= sat;
          s2_last_reg <= s1_last_reg;
          s2_user_reg <= s1_user_reg;
        end
      end
    end
  end

  assign bus.CFG_READY  = (state_reg == IDLE);
  assign bus.CFG_ERR    = cfg_err_reg;
  assign bus.IN_TREADY  = (state_reg == RUN) && s1_adv;
  assign bus.OUT_TVALID = s2_valid_reg;
  assign bus.OUT_TDATA  = s2_data_reg;
  assign bus.OUT_TLAST  = s2_last_reg;
  assign bus.OUT_TUSER  = s2_user_reg;
endmodule

// File: tb/tb_conv_out_requant.sv
// Self-checking bench for conv_out_requant: directed steps plus randomized frames
// scored against an arithmetic reference model (honours CONV_OUT_RELU_EN).
module tb_conv_out_requant;
  localparam int R = 8, C = 8, MAXK = 5, ACCW = 40, OW = 16;

  typedef struct {
    logic signed [15:0] d;
    logic               l;
    logic               u;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  conv_out_requant_if #(.ACCW(ACCW), .OW(OW), .MAXK(MAXK)) bus ();

  conv_out_requant #(.R(R), .C(C), .MAXK(MAXK), .ACCW(ACCW), .OW(OW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  exp_t exp_q[$];
  logic signed [15:0] obs_log[$];
  int cur_k = 3, cur_shift = 0, in_idx = 0;
  bit mon_en = 1'b0;
  bit rand_rdy = 1'b0;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: add half an LSB, floor-divide by 2^s, then clamp to the output range.
  function automatic logic signed [15:0] ref_q(input longint x, input int s);
    longint t;
    t = x;
    if (s > 0) t = t + (longint'(1) << (s - 1));
    t = t >>> s;
`ifdef CONV_OUT_RELU_EN
    if (t < 0) t = 0;
`endif
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
    return 16'(t);
  endfunction

  function automatic exp_t ref_beat(input longint x, input int idx, input int k, input int s);
    exp_t e;
    int w, n;
    w = C - k + 1;
    n = w * (R - k + 1);
    e.d = ref_q(x, s);
    e.l = ((idx % w) == (w - 1));
    e.u = (idx == n - 1);
    return e;
  endfunction

  // Output ready: always high, or random toggling.
  initial begin
    bus.OUT_TREADY = 1'b1;
    forever begin
      @(negedge clk);
      bus.OUT_TREADY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: feeds the model on input handshakes, scores output handshakes and stalls.
  initial begin
    bit hold_pending = 1'b0;
    logic [15:0] hold_d;
    logic hold_l, hold_u;
    int stall_acc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && mon_en) begin
        if (hold_pending) begin
          check("hold_valid", 64'(bus.OUT_TVALID), 64'd1);
          check("hold_data", 64'(bus.OUT_TDATA), 64'(hold_d));
          check("hold_tags", 64'({bus.OUT_TLAST, bus.OUT_TUSER}), 64'({hold_l, hold_u}));
        end
        if (bus.IN_TVALID && bus.IN_TREADY) begin
          exp_q.push_back(ref_beat(longint'($signed(bus.IN_TDATA)), in_idx, cur_k, cur_shift));
          in_idx++;
          if (!bus.OUT_TREADY) begin
            stall_acc++;
            check("stall_accepts_le2", 64'(stall_acc <= 2), 64'd1);
          end
        end
        if (bus.OUT_TREADY) stall_acc = 0;
        if (bus.OUT_TVALID && bus.OUT_TREADY) begin
          check("out_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_data", 64'($signed(bus.OUT_TDATA)), 64'(e.d));
            check("out_tlast", 64'(bus.OUT_TLAST), 64'(e.l));
            check("out_tuser", 64'(bus.OUT_TUSER), 64'(e.u));
          end
          obs_log.push_back($signed(bus.OUT_TDATA));
        end
        hold_pending = bus.OUT_TVALID && !bus.OUT_TREADY;
        hold_d = bus.OUT_TDATA;
        hold_l = bus.OUT_TLAST;
        hold_u = bus.OUT_TUSER;
      end else begin
        hold_pending = 1'b0;
        stall_acc = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  task automatic fail_timeout(input string tag);
    compared++;
    mismatched++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  task automatic configure(input int k, input int sh);
    @(negedge clk);
    bus.CFG_K = 3'(k);
    bus.CFG_SHIFT = 6'(sh);
    bus.CFG_VALID = 1'b1;
    cur_k = k;
    cur_shift = sh;
    in_idx = 0;
    @(negedge clk);
    bus.CFG_VALID = 1'b0;
  endtask

  task automatic send(input logic signed [39:0] v, input bit gaps);
    int t = 0;
    @(negedge clk);
    if (gaps && $urandom_range(0, 3) == 0) begin
      bus.IN_TVALID = 1'b0;
      @(negedge clk);
    end
    bus.IN_TDATA = v;
    bus.IN_TVALID = 1'b1;
    forever begin
      #1;
      if (bus.IN_TREADY) break;
      @(negedge clk);
      t++;
      if (t > 200) begin
        fail_timeout("send");
        break;
      end
    end
  endtask

  task automatic end_frame();
    int t = 0;
    @(negedge clk);
    bus.IN_TVALID = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() == 0 && bus.CFG_READY) break;
      t++;
      if (t > 300) begin
        fail_timeout("frame_drain");
        break;
      end
    end
    check("idle_cfg_ready", 64'(bus.CFG_READY), 64'd1);
    check("idle_in_tready", 64'(bus.IN_TREADY), 64'd0);
    check("idle_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic signed [39:0] rand_word();
    logic signed [39:0] v;
    v = 40'({$urandom, $urandom});
    if ($urandom_range(0, 1) == 1) v = v >>> $urandom_range(0, 39);
    return v;
  endfunction

  initial begin
    int n, k, sh;
    bus.CFG_K = '0;
    bus.CFG_SHIFT = '0;
    bus.CFG_VALID = 1'b0;
    bus.IN_TDATA = '0;
    bus.IN_TVALID = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #2;
    check("rst_out_tvalid", 64'(bus.OUT_TVALID), 64'd0);
    check("rst_out_tdata", 64'(bus.OUT_TDATA), 64'd0);
    check("rst_tags", 64'({bus.OUT_TLAST, bus.OUT_TUSER}), 64'd0);
    check("rst_cfg_ready", 64'(bus.CFG_READY), 64'd1);
    check("rst_cfg_err", 64'(bus.CFG_ERR), 64'd0);
    check("rst_in_tready", 64'(bus.IN_TREADY), 64'd0);
    mon_en = 1'b1;

    // Step 1: K=3 pass-through of a 0..35 ramp
    obs_log.delete();
    configure(3, 0);
    for (int i = 0; i < 36; i++) send(40'(i), 1'b0);
    end_frame();
    check("t1_beats", 64'(obs_log.size()), 64'd36);

    // Step 2: round-half-up at SHIFT=4
    obs_log.delete();
    configure(5, 4);
    send(40'sd24, 1'b0);
    send(40'sd23, 1'b0);
    send(-40'sd24, 1'b0);
    send(-40'sd25, 1'b0);
    for (int i = 4; i < 16; i++) send(rand_word(), 1'b0);
    end_frame();
    check("t2_beats", 64'(obs_log.size()), 64'd16);
    if (obs_log.size() >= 4) begin
      check("t2_24", 64'(obs_log[0]), 64'd2);
      check("t2_23", 64'(obs_log[1]), 64'd1);
`ifdef CONV_OUT_RELU_EN
      check("t2_m24", 64'(obs_log[2]), 64'd0);
      check("t2_m25", 64'(obs_log[3]), 64'd0);
`else
      check("t2_m24", 64'(obs_log[2]), -64'sd1);
      check("t2_m25", 64'(obs_log[3]), -64'sd2);
`endif
    end

    // Step 3: saturation at SHIFT=0
    obs_log.delete();
    configure(5, 0);
    send(40'sd1048576, 1'b0);
    send(-40'sd1048576, 1'b0);
    for (int i = 2; i < 16; i++) send(rand_word(), 1'b0);
    end_frame();
    if (obs_log.size() >= 2) begin
      check("t3_pos_sat", 64'(obs_log[0]), 64'sd32767);
`ifdef CONV_OUT_RELU_EN
      check("t3_neg_sat", 64'(obs_log[1]), 64'sd0);
`else
      check("t3_neg_sat", 64'(obs_log[1]), -64'sd32768);
`endif
    end

    // Step 4: illegal K values are rejected
    foreach (obs_log[i]) obs_log[i] = 16'sd0;
    for (int j = 0; j < 2; j++) begin
      bus.IN_TVALID = 1'b1;
      configure((j == 0) ? 6 : 0, 2);
      #2;
      check("t4_cfg_err", 64'(bus.CFG_ERR), 64'd1);
      check("t4_cfg_ready", 64'(bus.CFG_READY), 64'd1);
      check("t4_in_tready", 64'(bus.IN_TREADY), 64'd0);
      @(negedge clk);
      #2;
      check("t4_err_pulse", 64'(bus.CFG_ERR), 64'd0);
      check("t4_in_tready2", 64'(bus.IN_TREADY), 64'd0);
      bus.IN_TVALID = 1'b0;
    end

    // Step 5: random backpressure, ramps and random words, random K/SHIFT
    rand_rdy = 1'b1;
    for (int f = 0; f < 6; f++) begin
      k = $urandom_range(1, MAXK);
      sh = $urandom_range(0, 39);
      n = (R - k + 1) * (C - k + 1);
      obs_log.delete();
      configure(k, sh);
      for (int i = 0; i < n; i++) send((f < 3) ? 40'(i + 1) : rand_word(), 1'b1);
      end_frame();
      check("t5_beats", 64'(obs_log.size()), 64'(n));
    end
    rand_rdy = 1'b0;

    // Step 6: reset mid-frame, then a clean frame
    configure(3, 0);
    for (int i = 0; i < 10; i++) send(40'(100 + i), 1'b0);
    @(negedge clk);
    bus.IN_TVALID = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    in_idx = 0;
    #2;
    check("t6_out_tvalid", 64'(bus.OUT_TVALID), 64'd0);
    check("t6_in_tready", 64'(bus.IN_TREADY), 64'd0);
    check("t6_cfg_ready", 64'(bus.CFG_READY), 64'd1);
    obs_log.delete();
    configure(3, 0);
    for (int i = 0; i < 36; i++) send(40'(200 + i), 1'b0);
    end_frame();
    check("t6_beats", 64'(obs_log.size()), 64'd36);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
